// File: rtl/inst_ram_loader.sv
// Boot-time loader: receives a length-prefixed big-endian byte stream and writes
// it word by word into instruction RAM, holding the CPU in reset until complete.
module inst_ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        rearm,
  output logic        debug,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [31:0] inst_ram_write_address,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] ww_q, ww_d;

  logic in_ready_q, in_ready_d;
  logic debug_q, debug_d;
  logic we_q, we_d;
  logic cpu_reset_q, cpu_reset_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic        accept;
  logic [31:0] word;

  assign accept = in_valid && in_ready_q;
  assign word   = {shift_q, in_byte};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    ww_d    = ww_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = {16'h0000, in_byte};
          cnt_d   = 2'd1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          shift_d = word[23:0];
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            len_d = word[15:0];
            if (word == 32'd0)                 state_d = S_DONE;
            else if (word > 32'(MAX_WORDS))    state_d = S_ERR;
            else                               state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = word[23:0];
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wdata_d = word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        ww_d    = ww_q + 16'd1;
        addr_d  = addr_q + 32'd4;
        state_d = (ww_d == len_q) ? S_DONE : S_DATA;
      end
      S_DONE, S_ERR: begin
        if (rearm) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
          shift_d = '0;
          ww_d    = '0;
          addr_d  = BASE_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave a flop aligned with the state.
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LEN) || (state_d == S_DATA);
    debug_d     = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
    we_d        = (state_d == S_WRITE);
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      addr_q      <= BASE_ADDR;
      ww_q        <= '0;
      in_ready_q  <= 1'b1;
      debug_q     <= 1'b0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      ww_q        <= ww_d;
      in_ready_q  <= in_ready_d;
      debug_q     <= debug_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready               = in_ready_q;
  assign debug                  = debug_q;
  assign inst_ram_write_enable  = we_q;
  assign inst_ram_write_data    = wdata_q;
  assign inst_ram_write_address = addr_q;
  assign cpu_reset              = cpu_reset_q;
  assign done                   = done_q;
  assign error                  = error_q;
  assign words_written          = ww_q;

endmodule
